// File: rtl/dht_bus_scheduler.sv
// dht_bus_scheduler
// Shares one command source and one UART byte transmitter among N_SENSORS
// DHT11 controllers.
//   clk, reset            : system clock, synchronous active-high reset
//   cmd_valid/data/ready  : incoming 16-bit command ([4:0] address, [7:5] code)
//   comando, request      : command broadcast plus one-hot per-controller request
//   sensor_busy           : controller has left its wait-for-command state
//   buffer_ready, info_in : per-controller full response buffer and its word
//   buffer_used           : one-cycle acknowledge after a buffer was transmitted
//   tx_data/start/done    : UART byte interface
//   err_flag              : sticky request-timeout indicator
module dht_bus_scheduler #(
    parameter int unsigned N_SENSORS   = 4,
    parameter int unsigned REQ_TIMEOUT = 1000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    input  logic [15:0]             cmd_data,
    output logic                    cmd_ready,
    output logic [15:0]             comando,
    output logic [N_SENSORS-1:0]    request,
    input  logic [N_SENSORS-1:0]    sensor_busy,
    input  logic [N_SENSORS-1:0]    buffer_ready,
    input  logic [16*N_SENSORS-1:0] info_in,
    output logic [N_SENSORS-1:0]    buffer_used,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    tx_done,
    output logic                    err_flag
);

    localparam int unsigned IW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
    localparam int unsigned TW = $clog2(REQ_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI, ACK, HOLD
    } tx_state_t;

    // command path state
    logic          req_active;
    logic [IW-1:0] req_addr;
    logic          req_armed;
    logic [TW-1:0] req_cnt;
    logic          err_pend;
    logic [15:0]   err_word;

    // transmit path state
    tx_state_t     state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt;
    logic          gnt_err;
    logic [15:0]   word;
    logic          hold_cnt;

    logic [4:0]    cmd_addr;
    logic          addr_ok;
    logic          cmd_accept;
    logic          busy_sel;
    logic          err_clr;

    logic [15:0]   info_w [N_SENSORS];
    logic          arb_found;
    logic [IW-1:0] arb_idx;
    logic [15:0]   arb_word;
    int unsigned   cand;

    assign cmd_addr   = cmd_data[4:0];
    assign addr_ok    = 32'(cmd_addr) < N_SENSORS;
    assign cmd_ready  = !reset && !req_active && !err_pend;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign busy_sel   = sensor_busy[req_addr];
    assign err_clr    = (state == ACK) && gnt_err;

    for (genvar i = 0; i < N_SENSORS; i++) begin : g_info
        assign info_w[i] = info_in[16*i +: 16];
    end

    // Round-robin search starting at ptr; the first ready buffer wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < N_SENSORS; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N_SENSORS) cand = cand - N_SENSORS;
            if (!arb_found && buffer_ready[IW'(cand)]) begin
                arb_found = 1'b1;
                arb_idx   = IW'(cand);
            end
        end
        arb_word = info_w[arb_idx];
    end

    // Command path. req_armed records that busy has been seen low since the
    // request went up, so a controller already busy at raise time must
    // drop busy and raise it again before the request is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            comando    <= '0;
            request    <= '0;
            req_active <= 1'b0;
            req_addr   <= '0;
            req_armed  <= 1'b0;
            req_cnt    <= '0;
            err_pend   <= 1'b0;
            err_word   <= '0;
            err_flag   <= 1'b0;
        end else begin
            if (err_clr) err_pend <= 1'b0;
            if (cmd_accept) begin
                if (addr_ok) begin
                    comando                    <= cmd_data;
                    request                    <= '0;
                    request[cmd_addr[IW-1:0]]  <= 1'b1;
                    req_active                 <= 1'b1;
                    req_addr                   <= cmd_addr[IW-1:0];
                    req_armed                  <= 1'b0;
                    req_cnt                    <= '0;
                end else begin
                    err_pend <= 1'b1;
                    err_word <= {7'h00, 4'hF, cmd_addr};
                end
            end else if (req_active) begin
                if (busy_sel && req_armed) begin
                    request    <= '0;
                    req_active <= 1'b0;
                end else if (req_cnt == TW'(REQ_TIMEOUT - 1)) begin
                    request    <= '0;
                    req_active <= 1'b0;
                    err_flag   <= 1'b1;
                end else begin
                    req_cnt <= req_cnt + 1'b1;
                    if (!busy_sel) req_armed <= 1'b1;
                end
            end
        end
    end

    // Transmit FSM. Arbitration only happens in IDLE, so the two HOLD
    // cycles keep the just-served buffer out of the search while the
    // controller lowers its ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt         <= '0;
            gnt_err     <= 1'b0;
            word        <= '0;
            hold_cnt    <= 1'b0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            buffer_used <= '0;
        end else begin
            tx_start    <= 1'b0;
            buffer_used <= '0;
            case (state)
                IDLE: begin
                    if (err_pend) begin
                        word     <= err_word;
                        gnt_err  <= 1'b1;
                        tx_data  <= err_word[7:0];
                        tx_start <= 1'b1;
                        state    <= SEND_LO;
                    end else if (arb_found) begin
                        word     <= arb_word;
                        gnt      <= arb_idx;
                        gnt_err  <= 1'b0;
                        tx_data  <= arb_word[7:0];
                        tx_start <= 1'b1;
                        state    <= SEND_LO;
                    end
                end
                SEND_LO: state <= WAIT_LO;
                WAIT_LO: begin
                    if (tx_done) begin
                        tx_data  <= word[15:8];
                        tx_start <= 1'b1;
                        state    <= SEND_HI;
                    end
                end
                SEND_HI: state <= WAIT_HI;
                WAIT_HI: begin
                    if (tx_done) begin
                        if (!gnt_err) buffer_used[gnt] <= 1'b1;
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (!gnt_err) ptr <= (gnt == IW'(N_SENSORS - 1)) ? '0 : gnt + 1'b1;
                    hold_cnt <= 1'b0;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt) state <= IDLE;
                    else          hold_cnt <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dht_bus_scheduler.sv
// Self-checking bench for dht_bus_scheduler (N_SENSORS=4, REQ_TIMEOUT=20).
// A UART model acknowledges bytes after random latency; a round-robin
// reference model predicts frame order, bytes and buffer_used pulses.
module tb_dht_bus_scheduler;

    localparam int unsigned N   = 4;
    localparam int unsigned TMO = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic [15:0]   cmd_data;
    logic          cmd_ready;
    logic [15:0]   comando;
    logic [N-1:0]  request;
    logic [N-1:0]  sensor_busy;
    logic [N-1:0]  buffer_ready;
    logic [16*N-1:0] info_in;
    logic [N-1:0]  buffer_used;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_done;
    logic          tx_done_u;
    logic          tx_done_m;
    logic          err_flag;

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;
    bit            uart_en;
    int unsigned   mptr;
    logic [7:0]    rx_q [$];
    logic [N-1:0]  used_q [$];
    logic [15:0]   wd [N];

    assign tx_done = tx_done_u | tx_done_m;

    always #5 clk = ~clk;

    dht_bus_scheduler #(
        .N_SENSORS   (N),
        .REQ_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .comando      (comando),
        .request      (request),
        .sensor_busy  (sensor_busy),
        .buffer_ready (buffer_ready),
        .info_in      (info_in),
        .buffer_used  (buffer_used),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_done      (tx_done),
        .err_flag     (err_flag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rxb(input int unsigned i);
        return (rx_q.size() > i) ? rx_q[i] : 8'hxx;
    endfunction

    function automatic logic [N-1:0] usedb(input int unsigned i);
        return (used_q.size() > i) ? used_q[i] : 'x;
    endfunction

    // UART model: capture each launched byte, finish it after 1..5 cycles.
    initial begin
        tx_done_u = 1'b0;
        @(posedge clk); #1;
        forever begin
            if (tx_start && !reset) begin
                int unsigned lat;
                rx_q.push_back(tx_data);
                lat = $urandom_range(1, 5);
                repeat (lat) @(posedge clk);
                #1 tx_done_u = uart_en;
                @(posedge clk); #1 tx_done_u = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    // Record every cycle on which buffer_used is non-zero.
    initial forever begin
        @(negedge clk);
        if (buffer_used !== '0) used_q.push_back(buffer_used);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sensor_busy = '0;
        buffer_ready = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rx_q.delete();
        used_q.delete();
        mptr = 0;
        @(negedge clk);
    endtask

    // Drive a command and return on the negedge after it was accepted.
    task automatic send_cmd(input logic [15:0] c);
        int unsigned cyc;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = c;
        cyc = 0;
        while (!cmd_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("cmd_accept_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_data = 16'($urandom);
        @(negedge clk);
    endtask

    // Command with its expected outcome: a request released by busy after d
    // cycles, or an error frame for an out-of-range address.
    task automatic run_cmd(input logic [15:0] c, input int unsigned d);
        int unsigned a;
        int unsigned cyc;
        logic [15:0] ew;
        a = 32'(c[4:0]);
        send_cmd(c);
        if (a < N) begin
            check("request", 32'(request), 32'(1) << a);
            check("comando", 32'(comando), 32'(c));
            repeat (d) @(negedge clk);
            check("req_held", 32'(request), 32'(1) << a);
            sensor_busy[a] = 1'b1;
            @(negedge clk);
            check("req_drop", 32'(request), 0);
            check("ready_back", 32'(cmd_ready), 1);
            sensor_busy = '0;
        end else begin
            ew = {7'h00, 4'hF, c[4:0]};
            check("no_request", 32'(request), 0);
            check("ready_err", 32'(cmd_ready), 0);
            cyc = 0;
            while (rx_q.size() < 2 && cyc < 500) begin
                @(negedge clk);
                cyc++;
            end
            cyc = 0;
            while (!cmd_ready && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            check("err_lo", 32'(rxb(0)), 32'(ew[7:0]));
            check("err_hi", 32'(rxb(1)), 32'(ew[15:8]));
            check("ready_after_err", 32'(cmd_ready), 1);
            check("err_no_used", used_q.size(), 0);
            rx_q.delete();
        end
    endtask

    // Present buffers in mask; continuous controllers keep ready high for
    // ngr grants, otherwise each controller drops ready once acknowledged.
    task automatic serve(input logic [N-1:0] mask, input bit cont, input int unsigned ngr);
        bit           pend [N];
        logic [7:0]   exp_b [$];
        logic [N-1:0] exp_u [$];
        int unsigned  g, seen, cyc;
        for (int unsigned i = 0; i < N; i++) pend[i] = mask[i];
        for (int unsigned n = 0; n < ngr; n++) begin
            g = 0;
            for (int unsigned k = 0; k < N; k++) begin
                if (pend[(mptr + k) % N]) begin
                    g = (mptr + k) % N;
                    break;
                end
            end
            exp_u.push_back(N'(1) << g);
            exp_b.push_back(wd[g][7:0]);
            exp_b.push_back(wd[g][15:8]);
            if (!cont) pend[g] = 1'b0;
            mptr = (g + 1) % N;
        end
        rx_q.delete();
        used_q.delete();
        @(negedge clk);
        for (int unsigned i = 0; i < N; i++) info_in[16*i +: 16] = wd[i];
        buffer_ready = mask;
        seen = 0;
        cyc = 0;
        while (seen < ngr && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (buffer_used !== '0) begin
                seen++;
                if (!cont) buffer_ready = buffer_ready & ~buffer_used;
                if (seen == ngr) buffer_ready = '0;
            end
        end
        buffer_ready = '0;
        repeat (8) @(negedge clk);
        check("srv_nused", used_q.size(), exp_u.size());
        check("srv_nbytes", rx_q.size(), exp_b.size());
        foreach (exp_u[i]) check("srv_used", 32'(usedb(i)), 32'(exp_u[i]));
        foreach (exp_b[i]) check("srv_byte", 32'(rxb(i)), 32'(exp_b[i]));
        rx_q.delete();
        used_q.delete();
    endtask

    initial begin
        int unsigned cyc;
        int unsigned cnt;
        logic [N-1:0] m;
        bit cont;
        reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; sensor_busy = '0;
        buffer_ready = '0; info_in = '0; tx_done_m = 1'b0; uart_en = 1'b1; mptr = 0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_comando", 32'(comando), 0);
        check("rst_request", 32'(request), 0);
        check("rst_buffer_used", 32'(buffer_used), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_err_flag", 32'(err_flag), 0);
        reset = 1'b0;
        rx_q.delete();
        used_q.delete();
        @(negedge clk);
        check("ready_after_rst", 32'(cmd_ready), 1);

        // addr 2, busy 5 cycles later
        run_cmd(16'h0022, 5);

        // controller already busy when the request rises
        sensor_busy[1] = 1'b1;
        send_cmd(16'h0021);
        repeat (4) @(negedge clk);
        check("busy_pre_held", 32'(request), 32'h2);
        sensor_busy[1] = 1'b0;
        @(negedge clk);
        check("busy_low_held", 32'(request), 32'h2);
        sensor_busy[1] = 1'b1;
        @(negedge clk);
        check("busy_rise_drop", 32'(request), 0);
        sensor_busy = '0;

        // out-of-range address -> error frame E7 01
        run_cmd(16'h0007, 1);

        // single buffer, info changes and ready falls mid-frame
        rx_q.delete();
        used_q.delete();
        @(negedge clk);
        info_in[31:16] = 16'hA5C3;
        buffer_ready = 4'b0010;
        cyc = 0;
        while (rx_q.size() < 1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        info_in[31:16] = 16'h1234;
        buffer_ready = '0;
        cyc = 0;
        while (used_q.size() < 1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        repeat (6) @(negedge clk);
        check("t2_lo", 32'(rxb(0)), 32'hC3);
        check("t2_hi", 32'(rxb(1)), 32'hA5);
        check("t2_nbytes", rx_q.size(), 2);
        check("t2_used", 32'(usedb(0)), 32'h2);
        check("t2_used_once", used_q.size(), 1);

        // continuous 1011 from pointer 0
        do_reset();
        for (int unsigned i = 0; i < N; i++) wd[i] = 16'(16'h1111 * (i + 1));
        serve(4'b1011, 1'b1, 4);

        // randomized commands
        for (int unsigned t = 0; t < 24; t++) begin
            logic [15:0] r;
            r = 16'($urandom);
            run_cmd({r[15:5], 5'($urandom_range(0, 7))}, $urandom_range(1, 10));
        end

        // randomized buffer rounds
        for (int unsigned t = 0; t < 10; t++) begin
            for (int unsigned i = 0; i < N; i++) wd[i] = 16'($urandom);
            m = N'($urandom_range(1, 15));
            cont = 1'($urandom_range(0, 1));
            serve(m, cont, cont ? $urandom_range(1, 6) : $countones(m));
        end

        // request timeout
        check("pre_timeout_err", 32'(err_flag), 0);
        send_cmd(16'h0060);
        cnt = 0;
        while (request[0] && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_len", cnt, TMO);
        check("timeout_err", 32'(err_flag), 1);
        check("timeout_ready", 32'(cmd_ready), 1);
        repeat (10) @(negedge clk);
        check("err_sticky", 32'(err_flag), 1);

        // reset while waiting for the high byte's tx_done
        rx_q.delete();
        used_q.delete();
        @(negedge clk);
        info_in[63:48] = 16'hBEEF;
        buffer_ready = 4'b1000;
        cyc = 0;
        while (rx_q.size() < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        uart_en = 1'b0;
        check("wh_bytes", rx_q.size(), 2);
        @(negedge clk);
        reset = 1'b1;
        buffer_ready = '0;
        @(negedge clk);
        check("wh_tx_start", 32'(tx_start), 0);
        check("wh_tx_data", 32'(tx_data), 0);
        check("wh_buffer_used", 32'(buffer_used), 0);
        check("wh_request", 32'(request), 0);
        check("wh_comando", 32'(comando), 0);
        check("wh_err_flag", 32'(err_flag), 0);
        check("wh_cmd_ready", 32'(cmd_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        tx_done_m = 1'b1;
        @(negedge clk);
        tx_done_m = 1'b0;
        repeat (8) @(negedge clk);
        check("wh_no_used", used_q.size(), 0);
        check("wh_no_bytes", rx_q.size(), 2);
        check("wh_ready", 32'(cmd_ready), 1);
        uart_en = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
